// File: rtl/fetch_trap_sequencer.sv
// Fetch and trap-entry sequencer: drives the MAR/PC/IR load sequence and the
// ramMFA/ramMFC handshake, and turns overflow, bus-error and irq requests into vectored fetches.
module fetch_trap_sequencer #(
   parameter int ADDR_W     = 9,
   parameter int N_IRQ      = 4,
   parameter int TIMEOUT    = 15,
   parameter int OVF_VEC    = 448,
   parameter int BERR_VEC   = 464,
   parameter int IRQ_BASE   = 480,
   parameter int IRQ_STRIDE = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start_fetch,
   input  logic              ovf_trap,
   input  logic [N_IRQ-1:0]  irq,
   input  logic [N_IRQ-1:0]  irq_mask,
   input  logic              ramMFC,
   output logic              marEnable,
   output logic              pcEnable,
   output logic              irEnable,
   output logic              ramMFA,
   output logic              ramRW,
   output logic [1:0]        ramDataSize,
   output logic              trapMux,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [N_IRQ-1:0]  irq_ack,
   output logic [1:0]        trap_cause,
   output logic              fetch_done,
   output logic              bus_err,
   output logic              busy,
   output logic              halted,
   output logic [2:0]        state_dbg
);

   localparam int CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int IW       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_OVF  = 2'd1;
   localparam logic [1:0] CAUSE_BERR = 2'd2;
   localparam logic [1:0] CAUSE_IRQ  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_MAR = 3'd1,
      S_VECTOR   = 3'd2,
      S_REQ      = 3'd3,
      S_WAIT     = 3'd4,
      S_LOAD_IR  = 3'd5,
      S_HALT     = 3'd6
   } state_t;

   state_t          state, state_n;
   logic            ovf_pend, berr_pend;
   logic [CW-1:0]   wait_cnt;
   logic            irq_hit;
   logic [IW-1:0]   irq_idx;
   logic            take_ovf, take_berr, take_irq, take_norm;
   logic            tmo, tmo_hit;

   function automatic logic [ADDR_W-1:0] irq_vec(input int i);
      return ADDR_W'(IRQ_BASE + i * IRQ_STRIDE);
   endfunction

   // Lowest enabled index wins; scanning downward leaves the lowest hit last.
   always_comb begin
      irq_hit = 1'b0;
      irq_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq[i] && irq_mask[i]) begin
            irq_hit = 1'b1;
            irq_idx = IW'(i);
         end
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TMO_LAST));

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      take_ovf   = 1'b0;
      take_berr  = 1'b0;
      take_irq   = 1'b0;
      take_norm  = 1'b0;
      tmo        = 1'b0;
      marEnable  = 1'b0;
      pcEnable   = 1'b0;
      irEnable   = 1'b0;
      ramMFA     = 1'b0;
      fetch_done = 1'b0;
      irq_ack    = '0;
      case (state)
         S_IDLE: begin
            if (start_fetch) begin
               if (ovf_pend) begin
                  take_ovf = 1'b1;
                  state_n  = S_VECTOR;
               end else if (berr_pend) begin
                  take_berr = 1'b1;
                  state_n   = S_VECTOR;
               end else if (irq_hit) begin
                  take_irq         = 1'b1;
                  irq_ack[irq_idx] = 1'b1;
                  state_n          = S_VECTOR;
               end else begin
                  take_norm = 1'b1;
                  state_n   = S_LOAD_MAR;
               end
            end
         end
         S_LOAD_MAR: begin
            marEnable = 1'b1;
            state_n   = S_REQ;
         end
         S_VECTOR: state_n = S_REQ;
         S_REQ: begin
            ramMFA   = 1'b1;
            pcEnable = (trap_cause == CAUSE_NONE);
            state_n  = S_WAIT;
         end
         S_WAIT: begin
            ramMFA = 1'b1;
            // A completion on the last counted cycle still counts as success.
            if (ramMFC) begin
               state_n = S_LOAD_IR;
            end else if (tmo_hit) begin
               tmo     = 1'b1;
               state_n = (trap_cause == CAUSE_BERR) ? S_HALT : S_IDLE;
            end
         end
         S_LOAD_IR: begin
            irEnable   = 1'b1;
            fetch_done = 1'b1;
            state_n    = S_IDLE;
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         ovf_pend   <= 1'b0;
         berr_pend  <= 1'b0;
         ramAddress <= '0;
         trapMux    <= 1'b0;
         trap_cause <= CAUSE_NONE;
         wait_cnt   <= '0;
         bus_err    <= 1'b0;
      end else begin
         bus_err  <= tmo;
         // A new overflow request in the same cycle as the clear must not be lost.
         ovf_pend <= ovf_trap | (ovf_pend & ~take_ovf);
         if (take_berr)
            berr_pend <= 1'b0;
         else if (tmo && (trap_cause != CAUSE_BERR))
            berr_pend <= 1'b1;
         if (take_ovf) begin
            ramAddress <= ADDR_W'(OVF_VEC);
            trap_cause <= CAUSE_OVF;
            trapMux    <= 1'b1;
         end else if (take_berr) begin
            ramAddress <= ADDR_W'(BERR_VEC);
            trap_cause <= CAUSE_BERR;
            trapMux    <= 1'b1;
         end else if (take_irq) begin
            ramAddress <= irq_vec(int'(irq_idx));
            trap_cause <= CAUSE_IRQ;
            trapMux    <= 1'b1;
         end else if (take_norm) begin
            trap_cause <= CAUSE_NONE;
            trapMux    <= 1'b0;
         end
         if ((state == S_WAIT) && (state_n == S_WAIT) && (TIMEOUT != 0))
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   assign ramRW       = 1'b0;
   assign ramDataSize = 2'b11;
   assign busy        = (state != S_IDLE);
   assign halted      = (state == S_HALT);
   assign state_dbg   = state;

endmodule
